// File: rtl/inversek_pkg.sv
// inversek_pkg: shared word format, angle constants, arctan ROM and FSM states for inversek
package inversek_pkg;
  localparam int BIT_WIDTH = 32;
  localparam int FRACTIONS = 15;
  localparam logic signed [BIT_WIDTH-1:0] PI = 32'sd102944;
  localparam logic signed [BIT_WIDTH-1:0] TWO_PI = 32'sd205888;
  localparam logic signed [BIT_WIDTH-1:0] HALF_PI = 32'sd51472;
  // atan(2^-i) in Q.15; entries past 15 round to zero
  localparam logic signed [BIT_WIDTH-1:0] ATAN_ROM [24] = '{
    32'sd25736, 32'sd15193, 32'sd8027, 32'sd4075, 32'sd2045, 32'sd1024,
    32'sd512, 32'sd256, 32'sd128, 32'sd64, 32'sd32, 32'sd16,
    32'sd8, 32'sd4, 32'sd2, 32'sd1, 32'sd0, 32'sd0,
    32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0
  };
  typedef enum logic [3:0] {
    IDLE, MUL1, MUL2, SQRT, KTERM, CORD_A, CORD_B, CORD_C, FINAL
  } state_t;
endpackage

// File: rtl/cordic_vec.sv
// cordic_vec: time-shared CORDIC vectoring unit, atan2(yin, xin) in ITER+1 cycles after start
module cordic_vec import inversek_pkg::*; #(
  parameter int ITER = 16
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [BIT_WIDTH-1:0] xin,
  input  logic signed [BIT_WIDTH-1:0] yin,
  output logic                        done,
  output logic signed [BIT_WIDTH-1:0] angle
);
  localparam int W = BIT_WIDTH + 2;
  logic signed [W-1:0] xr, yr, xs, ys, xw, yw;
  logic signed [BIT_WIDTH-1:0] z;
  logic [4:0] i;
  logic busy, zero;
  assign xw = W'(xin);
  assign yw = W'(yin);
  assign xs = xr >>> i;
  assign ys = yr >>> i;
  assign angle = zero ? '0 : z;
  // left half-plane inputs are first turned by +/-pi/2 so the shift-add loop stays in range
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      xr <= '0;
      yr <= '0;
      z <= '0;
      i <= '0;
      busy <= 1'b0;
      zero <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      xr <= xin < 0 ? (yin < 0 ? -yw : yw) : xw;
      yr <= xin < 0 ? (yin < 0 ? xw : -xw) : yw;
      z <= xin < 0 ? (yin < 0 ? -HALF_PI : HALF_PI) : '0;
      zero <= xin == 0 && yin == 0;
      i <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      xr <= yr < 0 ? xr - ys : xr + ys;
      yr <= yr < 0 ? yr + xs : yr - xs;
      z <= yr < 0 ? z - ATAN_ROM[i] : z + ATAN_ROM[i];
      i <= i + 5'd1;
      busy <= int'(i) != ITER - 1;
      done <= int'(i) == ITER - 1;
    end else
      done <= 1'b0;
endmodule

// File: rtl/inversek.sv
// inversek: iterative Q.15 inverse kinematics for a 2-link planar arm, start/done handshake.
// Define INVERSEK_STATUS_EN to add the registered unreachable status output.
module inversek import inversek_pkg::*; #(
  parameter int L1 = 16384,
  parameter int L2 = 16384,
  parameter int ITER = 16
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [BIT_WIDTH-1:0] x,
  input  logic signed [BIT_WIDTH-1:0] y,
  output logic                        ready,
  output logic                        done,
  output logic signed [BIT_WIDTH-1:0] theta1,
  output logic signed [BIT_WIDTH-1:0] theta2
`ifdef INVERSEK_STATUS_EN
  ,
  output logic                        unreachable
`endif
);
  localparam longint ONE = 64'sd1 <<< FRACTIONS;
  localparam longint L1SQ = (longint'(L1) * longint'(L1)) >>> FRACTIONS;
  localparam longint L2SQ = (longint'(L2) * longint'(L2)) >>> FRACTIONS;
  localparam longint INV2L = (64'sd1 <<< 30) / ((2 * longint'(L1) * longint'(L2)) >>> FRACTIONS);
  state_t state, nstate;
  logic signed [BIT_WIDTH-1:0] xr, yr, c, s, k1, k2, t2, a, b, diff, wrapped, cxin, cyin, cangle;
  logic signed [63:0] d, craw, cclamp, u;
  logic [31:0] rad;
  logic [17:0] rem;
  logic [19:0] rem_sh, trial;
  logic [15:0] root;
  logic [3:0] cnt;
  logic fits, cstart, cdone;
  assign ready = state == IDLE;
  assign craw = ((d - L1SQ - L2SQ) * INV2L) >>> FRACTIONS;
  assign cclamp = craw > ONE ? ONE : craw < -ONE ? -ONE : craw;
  assign u = ONE - ((cclamp * cclamp) >>> FRACTIONS);
  // restoring square root of u scaled by 2^15, two radicand bits per step
  assign rem_sh = {rem, rad[31:30]};
  assign trial = {2'b00, root, 2'b01};
  assign fits = rem_sh >= trial;
  assign s = {16'b0, root};
  assign diff = a - b;
  assign wrapped = diff > PI ? diff - TWO_PI : diff < -PI ? diff + TWO_PI : diff;
  assign cxin = state == KTERM ? c : state == CORD_A ? xr : k1;
  assign cyin = state == KTERM ? s : state == CORD_A ? yr : k2;
  cordic_vec #(.ITER(ITER)) cordic (
    .clock(clock),
    .rst(rst),
    .start(cstart),
    .xin(cxin),
    .yin(cyin),
    .done(cdone),
    .angle(cangle)
  );
  always_ff @(posedge clock or posedge rst)
    if (rst) state <= IDLE;
    else state <= nstate;
  // the CORDIC is restarted on the same edge that collects the previous angle
  always_comb begin
    nstate = state;
    cstart = 1'b0;
    case (state)
      IDLE:   nstate = start ? MUL1 : IDLE;
      MUL1:   nstate = MUL2;
      MUL2:   nstate = SQRT;
      SQRT:   nstate = cnt == 4'd15 ? KTERM : SQRT;
      KTERM:  begin nstate = CORD_A; cstart = 1'b1; end
      CORD_A: begin nstate = cdone ? CORD_B : CORD_A; cstart = cdone; end
      CORD_B: begin nstate = cdone ? CORD_C : CORD_B; cstart = cdone; end
      CORD_C: nstate = cdone ? FINAL : CORD_C;
      FINAL:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      xr <= '0;
      yr <= '0;
      d <= '0;
      c <= '0;
      rad <= '0;
      rem <= '0;
      root <= '0;
      cnt <= '0;
      k1 <= '0;
      k2 <= '0;
      t2 <= '0;
      a <= '0;
      b <= '0;
      theta1 <= '0;
      theta2 <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          xr <= x;
          yr <= y;
        end
        MUL1: d <= (longint'(xr) * longint'(xr) + longint'(yr) * longint'(yr)) >>> FRACTIONS;
        MUL2: begin
          c <= 32'(cclamp);
          rad <= u > 0 ? 32'(u <<< FRACTIONS) : '0;
          rem <= '0;
          root <= '0;
          cnt <= '0;
        end
        SQRT: begin
          rem <= 18'(fits ? rem_sh - trial : rem_sh);
          root <= {root[14:0], fits};
          rad <= {rad[29:0], 2'b00};
          cnt <= cnt + 4'd1;
        end
        KTERM: begin
          k1 <= 32'(longint'(L1) + ((longint'(L2) * longint'(c)) >>> FRACTIONS));
          k2 <= 32'((longint'(L2) * longint'(s)) >>> FRACTIONS);
        end
        CORD_A: if (cdone) t2 <= cangle;
        CORD_B: if (cdone) a <= cangle;
        CORD_C: if (cdone) b <= cangle;
        FINAL: begin
          theta1 <= wrapped;
          theta2 <= t2;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
`ifdef INVERSEK_STATUS_EN
  logic unreach;
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      unreach <= 1'b0;
      unreachable <= 1'b0;
    end else begin
      if (state == MUL2) unreach <= craw > ONE || craw < -ONE;
      if (state == FINAL) unreachable <= unreach;
    end
`endif
endmodule

// File: tb/tb_inversek.sv
// tb_inversek: scoreboard bench for inversek; expected angles queued at accept, checked on done
module tb_inversek;
  localparam int LAT = 71;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [31:0] x = '0, y = '0;
  logic ready, done;
  logic signed [31:0] theta1, theta2;
`ifdef INVERSEK_STATUS_EN
  logic unreachable;
`endif
  int checks = 0, failures = 0, cyc = 0, dones = 0;
  typedef struct {
    int t1;
    int t2;
    int tol;
    bit unr;
    int acc;
  } exp_t;
  exp_t q[$];

  inversek dut (
    .clock(clock),
    .rst(rst),
    .start(start),
    .x(x),
    .y(y),
    .ready(ready),
    .done(done),
    .theta1(theta1),
    .theta2(theta2)
`ifdef INVERSEK_STATUS_EN
    ,
    .unreachable(unreachable)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    checks++;
    if (obs > exp + tol || obs < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // one clock step; every done pulse is matched against the scoreboard head
  task automatic tick;
    exp_t e;
    @(negedge clock);
    if (done) begin
      dones++;
      check("done_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("latency", cyc - e.acc, LAT);
        check("theta1", theta1, e.t1, e.tol);
        check("theta2", theta2, e.t2, e.tol);
`ifdef INVERSEK_STATUS_EN
        check("unreachable", int'(unreachable), int'(e.unr));
`endif
      end
    end
  endtask

  task automatic go(input int xi, input int yi, input int t1, input int t2, input int tol, input bit unr);
    int n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    check("ready_wait", int'(ready), 1);
    x = xi;
    y = yi;
    start = 1'b1;
    tick();
    q.push_back('{t1, t2, tol, unr, cyc});
    start = 1'b0;
    check("ready_drop", int'(ready), 0);
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    int d0;
    repeat (2) tick();
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_theta1", theta1, 0);
    check("rst_theta2", theta2, 0);
    rst = 1'b0;
    tick();
    go(32768, 0, 0, 0, 8, 1'b0);
    drain();
    go(0, 32768, 51472, 0, 8, 1'b0);
    drain();
    go(16384, 16384, 0, 51472, 8, 1'b0);
    drain();
    go(65536, 0, 0, 0, 8, 1'b1);
    drain();
    d0 = dones;
    go(16384, 16384, 0, 51472, 8, 1'b0);
    repeat (9) tick();
    x = 32768;
    y = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    drain();
    repeat (80) tick();
    check("single_done", dones - d0, 1);
    d0 = dones;
    go(0, 32768, 51472, 0, 8, 1'b0);
    repeat (28) tick();
    rst = 1'b1;
    #1;
    q.delete();
    check("abort_ready", int'(ready), 1);
    check("abort_done", int'(done), 0);
    check("abort_theta1", theta1, 0);
    check("abort_theta2", theta2, 0);
    tick();
    rst = 1'b0;
    repeat (100) tick();
    check("no_done_after_rst", dones - d0, 0);
    go(16384, 16384, 0, 51472, 8, 1'b0);
    drain();
    for (int k = 0; k < 100; k++) begin
      real t1, t2, xf, yf;
      t1 = real'(int'($urandom_range(0, 5600)) - 2800) / 1000.0;
      t2 = real'($urandom_range(700, 2400)) / 1000.0;
      xf = 0.5 * $cos(t1) + 0.5 * $cos(t1 + t2);
      yf = 0.5 * $sin(t1) + 0.5 * $sin(t1 + t2);
      go(int'(xf * 32768.0), int'(yf * 32768.0), int'(t1 * 32768.0), int'(t2 * 32768.0), 16, 1'b0);
      drain();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inversek.md
Name: inversek

Overview:
- Fixed-point inverse kinematics for the 2-joint planar arm. Maps an end-effector target (x, y) to joint angles (theta1, theta2).
- Inverse of the forwardk block. Same numeric format: 32-bit signed, 15 fraction bits, angles in radians. Lengths L1 and L2 match forwardk.
- Iterative and multi-cycle. A single time-shared CORDIC vectoring unit evaluates all atan2 terms. Uses a start/done handshake.

Parameters:
- BIT_WIDTH, 32, data word width (signed two's complement).
- FRACTIONS, 15, fraction bits of all data and angle words.
- L1, 16384, first link length in Q.FRACTIONS (0.5).
- L2, 16384, second link length in Q.FRACTIONS (0.5).
- ITER, 16, CORDIC micro-rotations per atan2 (range 8..24).

Ports:
- clock  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request; accepted only when ready=1.
- x  in  BIT_WIDTH  target x, Q.15 signed.
- y  in  BIT_WIDTH  target y, Q.15 signed.
- ready  out  1  idle, can accept start.
- done  out  1  one-cycle pulse: theta outputs updated.
- theta1  out  BIT_WIDTH  shoulder angle, radians Q.15, range [-pi, pi].
- theta2  out  BIT_WIDTH  elbow angle, radians Q.15, range [0, pi].

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ready=1, done=0, theta1=0, theta2=0.
  - All internal registers cleared.
  - Any operation in progress is aborted with no done pulse.
- Accept: a posedge with start=1 and ready=1 latches x and y; ready drops next cycle. start is ignored while ready=0.
- FSM order: IDLE -> MUL1 -> MUL2 -> SQRT -> KTERM -> CORD_A -> CORD_B -> CORD_C -> FINAL -> IDLE.
  - MUL1 (1 cycle): d = (x*x + y*y) >>> 15, 64-bit intermediates.
  - MUL2 (1 cycle):
    - c = ((d - L1sq - L2sq) * INV2L) >>> 15.
    - Clamp c to [-32768, 32768]; set unreach when clamping occurs.
    - u = 32768 - ((c*c) >>> 15).
  - SQRT (16 cycles): s = sqrt(u) in Q.15, restoring bit-serial, one result bit per cycle. u <= 0 gives s = 0.
  - KTERM (1 cycle): k1 = L1 + ((L2*c) >>> 15); k2 = (L2*s) >>> 15.
  - CORD_A (ITER+1 cycles): theta2 = atan2(s, c).
  - CORD_B (ITER+1 cycles): a = atan2(y, x).
  - CORD_C (ITER+1 cycles): b = atan2(k2, k1).
  - FINAL (1 cycle):
    - theta1 = a - b, wrapped into [-pi, pi] by +/-2pi (PI = 102944 / 2 = 51472 is pi/2, pi = 102944).
    - Register theta1 and theta2; done=1 for this cycle only. ready=1 from the next cycle.
- Latency: start accept edge to done = 20 + 3*(ITER+1) cycles (71 at ITER=16).
- CORDIC, per atan2:
  - 1 pre-rotation cycle: if xin < 0, rotate by +/-pi/2 (sign of yin), with angle seeded to +/-51472.
  - Then ITER shift-add iterations using the arctan ROM.
  - atan2(0, 0) = 0.
- Outputs hold their last value until the next done. done is never asserted twice for one start.
- Constants L1sq, L2sq, INV2L = 2^30 / (2*L1*L2 >> 15) are elaboration-time; 64-bit integer math.

Optional Feature:
- Macro INVERSEK_STATUS_EN.
- Defined: adds output port unreachable (1 bit), registered with theta outputs in FINAL.
  - Equals 1 iff c was clamped in MUL2; held until next done; reset value 0.
- Undefined: no port; clamping is silent; angles are identical either way.

Decomposition:
- Package inversek_pkg holds:
  - BIT_WIDTH and FRACTIONS.
  - PI and HALF_PI constants.
  - The atan ROM (24 entries, atan(2^-i) in Q.15).
  - The FSM state enum.
- Sub-module cordic_vec: start/done, xin, yin -> angle, ITER parameter. Instanced once and reused for CORD_A, CORD_B and CORD_C.

Test Plan:
- Full extension: x=32768, y=0 -> done after 71 cycles; theta1 = 0 +/-8 LSB, theta2 = 0 +/-8 LSB.
- Straight up: x=0, y=32768 -> theta1 = 51472 +/-8, theta2 = 0 +/-8.
- Elbow right angle: x=16384, y=16384 -> theta2 = 51472 +/-8, theta1 = 0 +/-8.
- Unreachable: x=65536, y=0 -> theta1 = 0, theta2 = 0 (+/-8); unreachable=1 when INVERSEK_STATUS_EN is defined.
- Handshake/reset:
  - A second start 10 cycles after accept is ignored (one done only).
  - rst pulsed at cycle 30 -> ready=1, theta=0, no done.
  - A fresh start afterwards gives the correct result.
- Round trip: the 100-vector theta1/theta2 input set through forwardk, then inversek -> each recovered angle within +/-16 LSB of the original (theta2 in [0, pi]).
